config_loader: RTL and testbench
================================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter NCELLS, default 16, number of 8-bit configuration cells addressed; legal range 2..16.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous assertion, active-low.
REQ-004 ser_en  input  1  frame enable, chip-select style; high for the duration of one frame.
REQ-005 ser_bit  input  1  serial data bit, MSB first; sampled only when ser_bit_valid=1.
REQ-006 ser_bit_valid  input  1  qualifies ser_bit for one clk cycle.
REQ-007 err_clr  input  1  one-cycle pulse clearing both sticky error flags.
REQ-008 din  output  8  write data to the configuration cells.
REQ-009 load  output  NCELLS  one-hot load strobes, one per configuration cell.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 parity_err  output  1  sticky flag: a frame had a parity error.
REQ-012 abort_err  output  1  sticky flag: a frame was truncated.
REQ-013 wr_count  output  8  count of successful cell writes.

Function
REQ-014 Frame SHALL be 13 bits: addr[3:0], then data[7:0], then one parity bit; even parity, so the XOR of all 13 bits SHALL be 0.
REQ-015 FSM states: IDLE, SHIFT, CHECK, LOAD, WAIT_END.
REQ-016 IDLE: ser_en=1 -> SHIFT, with the bit counter cleared; bits presented in the same cycle as the IDLE->SHIFT transition SHALL be ignored.
REQ-017 SHIFT: each cycle with ser_bit_valid=1 and ser_en=1 SHALL shift ser_bit into a 13-bit shift register and increment the bit counter.
REQ-018 SHIFT: acceptance of the 13th bit -> CHECK on the next edge.
REQ-019 SHIFT: ser_en=0 before 13 bits -> IDLE; shift register contents discarded; abort_err set; no load pulse.
REQ-020 CHECK (one cycle), parity good and addr<NCELLS -> LOAD.
REQ-021 CHECK, parity bad -> WAIT_END; parity_err set.
REQ-022 CHECK, parity good but addr>=NCELLS -> WAIT_END; no load; no flag.
REQ-023 LOAD: load[addr]=1 for exactly one cycle and all other load bits 0.
REQ-024 In the LOAD cycle, din SHALL equal the frame data.
REQ-025 In the LOAD cycle, wr_count SHALL increment modulo 256 (255 -> 0).
REQ-026 After the LOAD cycle, the FSM SHALL go to WAIT_END.
REQ-027 din SHALL be registered and SHALL hold the last loaded value until the next LOAD.
REQ-028 Latency: the load pulse SHALL be asserted exactly 2 clk cycles after the edge that captures the 13th bit.
REQ-029 WAIT_END: extra bits SHALL be ignored; ser_en=0 -> IDLE.
REQ-030 ser_en deassertion during CHECK or LOAD SHALL NOT abort the write already in progress.
REQ-031 err_clr clears both sticky flags; if a flag is set and err_clr is asserted in the same cycle, the set SHALL win.
REQ-032 busy SHALL be combinationally equal to (state != IDLE).

Reset
REQ-033 rstn=0 SHALL asynchronously force: state IDLE, shift register 0, bit counter 0, din 8'h00, load all 0, parity_err 0, abort_err 0, wr_count 0.
REQ-034 Reset asserted mid-frame SHALL drop the frame without any load pulse.
REQ-035 After reset release, operation SHALL restart from IDLE with the next ser_en rising.

Structure
REQ-036 Shared package config_loader_pkg SHALL hold the FSM state encoding, FRAME_BITS=13, ADDR_BITS=4 and DATA_BITS=8.
REQ-037 One sub-module, config_frame_shifter, SHALL contain the shift register, bit counter and parity XOR; the FSM and outputs live in config_loader.
REQ-038 All outputs SHALL be registered except busy.
REQ-039 The block SHALL contain no TMR; triplication is applied later by tool.

Verification
REQ-040 Good frame: addr=3, data=8'hA5, parity=0 -> load[3] one cycle 2 clk after the 13th bit; din=8'hA5; wr_count 0->1.
REQ-041 Bad parity: addr=3, data=8'hA5, parity=1 -> no load; parity_err=1 until err_clr; din unchanged.
REQ-042 Truncation: ser_en dropped after 7 bits -> abort_err=1; no load; busy low the next cycle.
REQ-043 Wrap and gaps: 256 good frames with random ser_bit_valid gaps -> wr_count returns to 0 and every load is one-hot.
REQ-044 Reset mid-frame: rstn pulsed low at bit 10 -> all outputs at reset values; the following good frame to addr=15, data=8'h3C loads correctly.
REQ-045 Extra bits and clear race: 20 bits sent under one ser_en -> exactly one load from the first 13 bits; err_clr asserted in the same cycle as a parity failure -> parity_err=1.

Source files
------------

// File: rtl/config_loader_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | config_loader_pkg : frame geometry and FSM encoding              |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package config_loader_pkg;

  localparam int FRAME_BITS = 13;
  localparam int ADDR_BITS  = 4;
  localparam int DATA_BITS  = 8;
  localparam int CNT_BITS   = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT    = 3'd1,
    CHECK    = 3'd2,
    LOAD     = 3'd3,
    WAIT_END = 3'd4
  } state_t;

endpackage : config_loader_pkg
`default_nettype wire

// File: rtl/config_frame_shifter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | config_frame_shifter : MSB-first frame shift register, bit count |
// | and even-parity check. Rev 1.0                                   |
// +-----------------------------------------------------------------+
module config_frame_shifter
  import config_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  shiftEn,
  input  logic                  serBit,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  parityOk,
  output logic                  frameDone
);

  logic [CNT_BITS-1:0] r_bitCount;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame      <= '0;
      r_bitCount <= '0;
    end else if (clear) begin
      frame      <= '0;
      r_bitCount <= '0;
    end else if (shiftEn) begin
      frame      <= {frame[FRAME_BITS-2:0], serBit};
      r_bitCount <= r_bitCount + CNT_BITS'(1);
    end
  end

  assign parityOk  = ~^frame;
  // High in the cycle whose edge will accept the final frame bit.
  assign frameDone = shiftEn && (r_bitCount == CNT_BITS'(FRAME_BITS - 1));

endmodule : config_frame_shifter
`default_nettype wire

// File: rtl/config_loader.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | config_loader : serial frame receiver writing 8-bit config cells |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module config_loader
  import config_loader_pkg::*;
#(
  parameter int NCELLS = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ser_en,
  input  logic                 ser_bit,
  input  logic                 ser_bit_valid,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] din,
  output logic [NCELLS-1:0]    load,
  output logic                 busy,
  output logic                 parity_err,
  output logic                 abort_err,
  output logic [7:0]           wr_count
);

  localparam logic [ADDR_BITS:0] C_NCELLS = (ADDR_BITS + 1)'(NCELLS);

  state_t                 r_state;
  logic [FRAME_BITS-1:0]  w_frame;
  logic                   w_parityOk;
  logic                   w_frameDone;
  logic                   w_shiftEn;
  logic                   w_clear;
  logic [ADDR_BITS-1:0]   w_addr;
  logic [DATA_BITS-1:0]   w_data;
  logic                   w_addrOk;
  logic                   w_paritySet;
  logic                   w_abortSet;

  assign w_shiftEn   = (r_state == SHIFT) && ser_en && ser_bit_valid;
  assign w_clear     = (r_state == IDLE);
  assign w_addr      = w_frame[FRAME_BITS-1 -: ADDR_BITS];
  assign w_data      = w_frame[DATA_BITS:1];
  assign w_addrOk    = ({1'b0, w_addr} < C_NCELLS);
  assign w_paritySet = (r_state == CHECK) && !w_parityOk;
  assign w_abortSet  = (r_state == SHIFT) && !ser_en;
  assign busy        = (r_state != IDLE);

  config_frame_shifter u_shifter (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (w_clear),
    .shiftEn   (w_shiftEn),
    .serBit    (ser_bit),
    .frame     (w_frame),
    .parityOk  (w_parityOk),
    .frameDone (w_frameDone)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      din        <= '0;
      load       <= '0;
      parity_err <= 1'b0;
      abort_err  <= 1'b0;
      wr_count   <= '0;
    end else begin
      load       <= '0;
      // A new error outranks a coincident clear.
      parity_err <= w_paritySet | (parity_err & ~err_clr);
      abort_err  <= w_abortSet  | (abort_err  & ~err_clr);
      case (r_state)
        IDLE: begin
          if (ser_en) r_state <= SHIFT;
        end
        SHIFT: begin
          if (!ser_en)          r_state <= IDLE;
          else if (w_frameDone) r_state <= CHECK;
        end
        CHECK: begin
          if (w_parityOk && w_addrOk) r_state <= LOAD;
          else                        r_state <= WAIT_END;
        end
        LOAD: begin
          load     <= NCELLS'(1) << w_addr;
          din      <= w_data;
          wr_count <= wr_count + 8'd1;
          r_state  <= WAIT_END;
        end
        WAIT_END: begin
          if (!ser_en) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : config_loader
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_config_loader : directed self-checking bench for config_loader|
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_config_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ser_en = 1'b0;
  logic        ser_bit = 1'b0;
  logic        ser_bit_valid = 1'b0;
  logic        err_clr = 1'b0;
  logic [7:0]  din;
  logic [15:0] load;
  logic        busy;
  logic        parity_err;
  logic        abort_err;
  logic [7:0]  wr_count;

  int          checks = 0;
  int          failures = 0;
  int          loadPulses = 0;
  logic [15:0] lastLoad = '0;

  config_loader #(.NCELLS(16)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .ser_en        (ser_en),
    .ser_bit       (ser_bit),
    .ser_bit_valid (ser_bit_valid),
    .err_clr       (err_clr),
    .din           (din),
    .load          (load),
    .busy          (busy),
    .parity_err    (parity_err),
    .abort_err     (abort_err),
    .wr_count      (wr_count)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (load !== 16'h0) begin
      loadPulses++;
      lastLoad = load;
      checkVal("load_onehot", 32'($countones(load)), 32'd1);
    end
  end

  function automatic logic [12:0] mkFrame(input logic [3:0] a, input logic [7:0] d, input logic flip);
    return {a, d, (^{a, d}) ^ flip};
  endfunction

  // Raises ser_en with a junk bit in the IDLE->SHIFT cycle, which must be ignored.
  task automatic startFrame();
    @(negedge clk);
    ser_en = 1'b1;
    ser_bit = 1'b1;
    ser_bit_valid = 1'b1;
  endtask

  task automatic sendBits(input logic [31:0] vec, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps) begin
        int g = int'($urandom_range(0, 2));
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          ser_bit_valid = 1'b0;
          ser_bit = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
      ser_bit = vec[i];
      ser_bit_valid = 1'b1;
    end
  endtask

  // Idle cycles past the load slot, then close the frame and return to IDLE.
  task automatic closeFrame();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ser_bit_valid = 1'b0;
    end
    ser_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int p0;
    logic [3:0] a;
    logic [7:0] d;

    // Reset values
    repeat (2) @(negedge clk);
    checkVal("rst_din", 32'(din), 32'h00);
    checkVal("rst_load", 32'(load), 32'h0);
    checkVal("rst_busy", 32'(busy), 32'd0);
    checkVal("rst_perr", 32'(parity_err), 32'd0);
    checkVal("rst_aerr", 32'(abort_err), 32'd0);
    checkVal("rst_wrcnt", 32'(wr_count), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Good frame, exact latency: addr 3, data A5
    p0 = loadPulses;
    startFrame();
    sendBits(32'(mkFrame(4'd3, 8'hA5, 1'b0)), 13, 1'b0);
    @(negedge clk); ser_bit_valid = 1'b0;
    checkVal("good_busy", 32'(busy), 32'd1);
    checkVal("good_lat1", 32'(load), 32'h0);
    @(negedge clk);
    checkVal("good_lat2", 32'(load), 32'h0);
    @(negedge clk);
    checkVal("good_load", 32'(load), 32'h0008);
    checkVal("good_din", 32'(din), 32'hA5);
    checkVal("good_wrcnt", 32'(wr_count), 32'd1);
    @(negedge clk);
    checkVal("good_load_off", 32'(load), 32'h0);
    ser_en = 1'b0;
    @(negedge clk);
    checkVal("good_idle", 32'(busy), 32'd0);
    checkVal("good_pulses", 32'(loadPulses - p0), 32'd1);

    // Bad parity
    p0 = loadPulses;
    startFrame();
    sendBits(32'(mkFrame(4'd3, 8'h5A, 1'b1)), 13, 1'b0);
    closeFrame();
    checkVal("bad_pulses", 32'(loadPulses - p0), 32'd0);
    checkVal("bad_perr", 32'(parity_err), 32'd1);
    checkVal("bad_din", 32'(din), 32'hA5);
    checkVal("bad_wrcnt", 32'(wr_count), 32'd1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    checkVal("bad_perr_clr", 32'(parity_err), 32'd0);

    // Truncation after 7 bits
    p0 = loadPulses;
    startFrame();
    sendBits(32'(mkFrame(4'd2, 8'h11, 1'b0) >> 6), 7, 1'b0);
    @(negedge clk);
    ser_en = 1'b0;
    ser_bit_valid = 1'b0;
    @(negedge clk);
    checkVal("trunc_aerr", 32'(abort_err), 32'd1);
    checkVal("trunc_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    checkVal("trunc_pulses", 32'(loadPulses - p0), 32'd0);
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    checkVal("trunc_aerr_clr", 32'(abort_err), 32'd0);

    // 20 bits under one ser_en: only the first 13 count
    p0 = loadPulses;
    startFrame();
    sendBits({12'h0, mkFrame(4'd5, 8'h5A, 1'b0), 7'b1011001}, 20, 1'b0);
    closeFrame();
    checkVal("extra_pulses", 32'(loadPulses - p0), 32'd1);
    checkVal("extra_load", 32'(lastLoad), 32'h0020);
    checkVal("extra_din", 32'(din), 32'h5A);
    checkVal("extra_wrcnt", 32'(wr_count), 32'd2);

    // err_clr coincides with the parity failure: set wins
    checkVal("race_pre", 32'(parity_err), 32'd0);
    startFrame();
    sendBits(32'(mkFrame(4'd7, 8'hC3, 1'b1)), 13, 1'b0);
    @(negedge clk);
    ser_bit_valid = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkVal("race_perr", 32'(parity_err), 32'd1);
    closeFrame();
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;

    // Reset at bit 10, then a good frame to addr 15
    p0 = loadPulses;
    startFrame();
    sendBits(32'(mkFrame(4'd15, 8'h3C, 1'b0) >> 3), 10, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    ser_en = 1'b0;
    ser_bit_valid = 1'b0;
    @(negedge clk);
    checkVal("mrst_din", 32'(din), 32'h00);
    checkVal("mrst_wrcnt", 32'(wr_count), 32'd0);
    checkVal("mrst_busy", 32'(busy), 32'd0);
    checkVal("mrst_perr", 32'(parity_err), 32'd0);
    repeat (3) @(negedge clk);
    checkVal("mrst_pulses", 32'(loadPulses - p0), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    startFrame();
    sendBits(32'(mkFrame(4'd15, 8'h3C, 1'b0)), 13, 1'b0);
    closeFrame();
    checkVal("mrst_load", 32'(lastLoad), 32'h8000);
    checkVal("mrst_din2", 32'(din), 32'h3C);
    checkVal("mrst_wrcnt2", 32'(wr_count), 32'd1);

    // 256 good frames with valid gaps: counter wraps through zero
    p0 = loadPulses;
    for (int i = 1; i <= 256; i++) begin
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      startFrame();
      sendBits(32'(mkFrame(a, d, 1'b0)), 13, 1'b1);
      closeFrame();
      checkVal("wrap_din", 32'(din), 32'(d));
      checkVal("wrap_load", 32'(lastLoad), 32'(16'h1 << a));
      if (i == 255) checkVal("wrap_zero", 32'(wr_count), 32'd0);
    end
    checkVal("wrap_wrcnt", 32'(wr_count), 32'd1);
    checkVal("wrap_pulses", 32'(loadPulses - p0), 32'd256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_config_loader
`default_nettype wire
